// File: rtl/sensor_interval_timer.sv
// Debounces two track sensors and times S1->S2 transit in ticks.
// Optional SENSOR_BIDIR_EN adds dir output and S2->S1 timing.
`timescale 1ns/1ps
module sensor_interval_timer #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int TICK_HZ     = 1000,
   parameter int CNT_W       = 15,
   parameter int DEB_CYCLES  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s1_in,
   input  logic             s2_in,
   output logic [CNT_W-1:0] interval_ms,
   output logic             interval_valid,
   output logic             busy,
   output logic             timeout
`ifdef SENSOR_BIDIR_EN
   ,
   output logic             dir
`endif
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW  = $clog2(DEB_CYCLES + 1);
   localparam logic [PW-1:0]    P_LAST  = PW'(DIV - 1);
   localparam logic [DW-1:0]    D_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      S_IDLE,
      S_TIMING
   } state_t;

   state_t r_state, w_state_nx;

   logic [1:0]    w_raw;
   logic [1:0]    r_meta, r_sync, r_deb, r_ev;
   logic [DW-1:0] r_dcnt [2];

   logic [PW-1:0]    r_presc;
   logic [CNT_W-1:0] r_cnt, w_cnt_inc, w_cnt_now;
   logic [CNT_W-1:0] r_interval;
   logic             r_valid, r_busy, r_timeout;
   logic             w_tick, w_start, w_close, w_retrig, w_tout;
   logic             w_start_ev, w_close_ev, w_re_ev;

   assign w_raw = {s2_in, s1_in};

   // Sync, debounce and rising-edge event, one lane per sensor
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
         r_deb  <= '0;
         r_ev   <= '0;
         for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
      end else begin
         r_meta <= w_raw;
         r_sync <= r_meta;
         for (int i = 0; i < 2; i++) begin
            r_ev[i] <= 1'b0;
            if (r_sync[i] != r_deb[i]) begin
               if (r_dcnt[i] == D_LAST) begin
                  r_dcnt[i] <= '0;
                  r_deb[i]  <= r_sync[i];
                  r_ev[i]   <= r_sync[i];
               end else begin
                  r_dcnt[i] <= r_dcnt[i] + DW'(1);
               end
            end else begin
               r_dcnt[i] <= '0;
            end
         end
      end
   end

`ifdef SENSOR_BIDIR_EN
   logic r_run_dir, r_dir;
   logic w_start_dir;
   assign w_start_ev  = r_ev[0] | r_ev[1];
   assign w_start_dir = ~r_ev[0];
   assign w_close_ev  = r_run_dir ? r_ev[0] : r_ev[1];
   assign w_re_ev     = r_run_dir ? r_ev[1] : r_ev[0];
   assign dir         = r_dir;
`else
   assign w_start_ev  = r_ev[0];
   assign w_close_ev  = r_ev[1];
   assign w_re_ev     = r_ev[0];
`endif

   assign w_tick    = (r_state == S_TIMING) && (r_presc == P_LAST);
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   // Close uses the count including a tick landing in the same cycle
   assign w_cnt_now = w_tick ? w_cnt_inc : r_cnt;

   always_comb begin
      w_state_nx = r_state;
      w_start    = 1'b0;
      w_close    = 1'b0;
      w_retrig   = 1'b0;
      w_tout     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_start_ev) begin
               w_start    = 1'b1;
               w_state_nx = S_TIMING;
            end
         end
         S_TIMING: begin
            if (w_close_ev) begin
               w_close    = 1'b1;
               w_state_nx = S_IDLE;
            end else if (w_re_ev) begin
               w_retrig   = 1'b1;
            end else if (w_tick && (w_cnt_inc == CNT_MAX)) begin
               w_tout     = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc    <= '0;
         r_cnt      <= '0;
         r_interval <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
`ifdef SENSOR_BIDIR_EN
         r_run_dir  <= 1'b0;
         r_dir      <= 1'b0;
`endif
      end else begin
         r_valid   <= w_close;
         r_timeout <= w_tout;
         r_busy    <= (w_state_nx == S_TIMING);
         if (w_start || w_retrig) begin
            r_presc <= '0;
            r_cnt   <= '0;
         end else if (r_state == S_TIMING) begin
            r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
            if (w_tick) r_cnt <= w_cnt_inc;
         end
         // Floor of 1 keeps the downstream divider away from zero
         if (w_close) begin
            r_interval <= (w_cnt_now == '0) ? CNT_W'(1) : w_cnt_now;
         end
`ifdef SENSOR_BIDIR_EN
         if (w_start) r_run_dir <= w_start_dir;
         if (w_close) r_dir <= r_run_dir;
`endif
      end
   end

   assign interval_ms    = r_interval;
   assign interval_valid = r_valid;
   assign busy           = r_busy;
   assign timeout        = r_timeout;

endmodule
